code_lock_ctrl: RTL and testbench

//  Parametrised keypad door-lock controller; next generation of the fixed 6-digit lockeddoor block.

---
 rtl/lock_pkg.sv | 28 ++
 rtl/keypad_event.sv | 57 +++++
 rtl/code_lock_ctrl.sv | 161 ++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types for the keypad code lock: FSM states, key line indices
// and the one-hot key to index encoder.
package lock_pkg;

  localparam int KEY_W    = 12;
  localparam int KEY_STAR = 10;
  localparam int KEY_HASH = 11;

  typedef enum logic [2:0] {
    ENTRY,
    CHECK,
    OPEN,
    PROG,
    LOCKOUT
  } state_e;

  // Lowest set line wins; callers only pass one-hot values.
  function automatic logic [3:0] onehot_to_digit(
    input logic [KEY_W-1:0] k
  );
    logic [3:0] d;
    d = '0;
    for (int i = KEY_W - 1; i >= 0; i--)
      if (k[i]) d = 4'(i);
    return d;
  endfunction

endpackage

// File: rtl/keypad_event.sv
// Keypad front end: 2-flop synchroniser, edge detect and one-hot filter.
// Ports: clk, reset, key_i[11:0] in; ev_valid, ev_digit[3:0], ev_star, ev_hash out.
module keypad_event
  import lock_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_i,
  output logic             ev_valid,
  output logic [3:0]       ev_digit,
  output logic             ev_star,
  output logic             ev_hash
);

  logic [KEY_W-1:0] sync1_q, sync2_q, prev_q;
  logic             ev_valid_q, ev_valid_d;
  logic             ev_star_q, ev_star_d;
  logic             ev_hash_q, ev_hash_d;
  logic [3:0]       ev_digit_q, ev_digit_d;
  logic             one_hot;

  always_comb begin
    one_hot    = (sync2_q != '0) &&
                 ((sync2_q & (sync2_q - KEY_W'(1))) == '0);
    // Release and multi-hot fall out here; a held key fires once.
    ev_valid_d = one_hot && (sync2_q != prev_q);
    ev_digit_d = onehot_to_digit(sync2_q);
    ev_star_d  = ev_valid_d && sync2_q[KEY_STAR];
    ev_hash_d  = ev_valid_d && sync2_q[KEY_HASH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_digit_q <= '0;
      ev_star_q  <= 1'b0;
      ev_hash_q  <= 1'b0;
    end else begin
      sync1_q    <= key_i;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      ev_valid_q <= ev_valid_d;
      ev_digit_q <= ev_digit_d;
      ev_star_q  <= ev_star_d;
      ev_hash_q  <= ev_hash_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_digit = ev_digit_q;
  assign ev_star  = ev_star_q;
  assign ev_hash  = ev_hash_q;

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad door-lock controller: code entry, timed open, lockout, reprogramming.
// Ports: clk, reset, inputChar[11:0] in; open, locked_out, prog_mode, err, fail_cnt out.
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned           CODE_LEN       = 6,
  parameter int unsigned           OPEN_CYCLES    = 20,
  parameter int unsigned           MAX_FAILS      = 3,
  parameter int unsigned           LOCKOUT_CYCLES = 100,
  parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE   = 24'h654321
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [KEY_W-1:0]               inputChar,
  output logic                           open,
  output logic                           locked_out,
  output logic                           prog_mode,
  output logic                           err,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int DW   = 4 * CODE_LEN;
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int FW   = $clog2(MAX_FAILS + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                        OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_e          state_q, state_d;
  logic [DW-1:0]   entry_q, entry_d, entry_ins;
  logic [DW-1:0]   stored_q, stored_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;

  logic            ev_valid, ev_star, ev_hash, ev_dig;
  logic [3:0]      ev_digit;

  keypad_event u_kev (
    .clk      (clk),
    .reset    (reset),
    .key_i    (inputChar),
    .ev_valid (ev_valid),
    .ev_digit (ev_digit),
    .ev_star  (ev_star),
    .ev_hash  (ev_hash)
  );

  assign ev_dig = ev_valid && !ev_star && !ev_hash;

  // Digit n lands in nibble n, so the first key sits in [3:0].
  always_comb begin
    entry_ins = entry_q;
    for (int i = 0; i < CODE_LEN; i++)
      if (cnt_q == CW'(i)) entry_ins[4*i +: 4] = ev_digit;
  end

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    stored_d = stored_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    unique case (state_q)
      ENTRY: begin
        if (ev_dig) begin
          entry_d = entry_ins;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(CODE_LEN - 1)) state_d = CHECK;
        end else if ((ev_star || ev_hash) && cnt_q != '0) begin
          entry_d = '0;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        entry_d = '0;
        cnt_d   = '0;
        if (entry_q == stored_q) begin
          state_d = OPEN;
          fail_d  = '0;
          timer_d = TW'(OPEN_CYCLES - 1);
        end else begin
          err_d  = 1'b1;
          fail_d = fail_q + FW'(1);
          if (fail_q == FW'(MAX_FAILS - 1)) begin
            state_d = LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = ENTRY;
          end
        end
      end
      OPEN: begin
        // Expiry is checked first so a coincident key is dropped.
        if (timer_q == '0) begin
          state_d = ENTRY;
        end else if (ev_star) begin
          state_d = PROG;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      PROG: begin
        if (ev_dig && cnt_q != CW'(CODE_LEN)) begin
          entry_d = entry_ins;
          cnt_d   = cnt_q + CW'(1);
        end else if (ev_hash && cnt_q == CW'(CODE_LEN)) begin
          stored_d = entry_q;
          entry_d  = '0;
          cnt_d    = '0;
          state_d  = ENTRY;
        end else if (ev_valid) begin
          err_d   = 1'b1;
          entry_d = '0;
          cnt_d   = '0;
          state_d = ENTRY;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = ENTRY;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ENTRY;
      entry_q  <= '0;
      stored_q <= DEFAULT_CODE;
      cnt_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      stored_q <= stored_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  assign open       = (state_q == OPEN);
  assign locked_out = (state_q == LOCKOUT);
  assign prog_mode  = (state_q == PROG);
  assign err        = err_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: key-level reference model feeds
// an expectation queue; a negedge monitor pops and compares.
module tb_code_lock_ctrl;

  localparam int CL = 6;
  localparam int OC = 20;
  localparam int MF = 3;
  localparam int LC = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] inputChar = '0;
  logic        open, locked_out, prog_mode, err;
  logic [1:0]  fail_cnt;

  code_lock_ctrl #(
    .CODE_LEN       (CL),
    .OPEN_CYCLES    (OC),
    .MAX_FAILS      (MF),
    .LOCKOUT_CYCLES (LC),
    .DEFAULT_CODE   (24'h654321)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inputChar  (inputChar),
    .open       (open),
    .locked_out (locked_out),
    .prog_mode  (prog_mode),
    .err        (err),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_ERR, K_OPEN, K_LOCK, K_PROG} kind_e;
  typedef struct {
    kind_e kind;
    int    at;
    int    fails;
  } exp_t;
  exp_t expq[$];

  typedef enum {M_ENTRY, M_OPEN, M_PROG, M_LOCK} mode_e;
  mode_e mode;
  int    dig[$];
  int    code[CL];
  int    fails;
  int    t_end;

  function automatic void push(input kind_e k, input int at, input int f);
    exp_t x;
    x.kind  = k;
    x.at    = at;
    x.fails = f;
    expq.push_back(x);
  endfunction

  function automatic void m_reset();
    mode = M_ENTRY;
    dig.delete();
    for (int i = 0; i < CL; i++) code[i] = i + 1;
    fails = 0;
    t_end = 0;
    expq.delete();
  endfunction

  // Event with strobe at cycle e is acted on at edge e+1.
  function automatic void m_event(input int key, input int e);
    int  p;
    bit  is_dig, match;
    p = e + 1;
    is_dig = key < 10;
    if (mode == M_LOCK) begin
      if (p <= t_end) return;
      fails = 0;
      mode  = M_ENTRY;
    end
    if (mode == M_OPEN) begin
      if (p == t_end) return;
      if (p > t_end) mode = M_ENTRY;
    end
    case (mode)
      M_ENTRY: begin
        if (is_dig) begin
          dig.push_back(key);
          if (dig.size() == CL) begin
            match = 1;
            for (int i = 0; i < CL; i++)
              if (dig[i] != code[i]) match = 0;
            dig.delete();
            if (match) begin
              mode  = M_OPEN;
              fails = 0;
              t_end = p + 1 + OC;
              push(K_OPEN, p + 1, 0);
            end else begin
              fails++;
              push(K_ERR, p + 1, fails);
              if (fails == MF) begin
                mode  = M_LOCK;
                t_end = p + 1 + LC;
                push(K_LOCK, p + 1, 0);
              end
            end
          end
        end else if (dig.size() > 0) begin
          dig.delete();
        end
      end
      M_OPEN: begin
        if (key == 10) begin
          mode = M_PROG;
          dig.delete();
          push(K_PROG, p, 0);
        end
      end
      M_PROG: begin
        if (is_dig && dig.size() < CL) begin
          dig.push_back(key);
        end else if (key == 11 && dig.size() == CL) begin
          for (int i = 0; i < CL; i++) code[i] = dig[i];
          dig.delete();
          mode = M_ENTRY;
        end else begin
          push(K_ERR, p, fails);
          dig.delete();
          mode = M_ENTRY;
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [11:0] v, input int gap);
    int k;
    k = cyc;
    inputChar = v;
    if ($countones(v) == 1)
      for (int i = 0; i < 12; i++)
        if (v[i]) m_event(i, k + 3);
    repeat (10) @(posedge clk);
    #1 inputChar = '0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic key(input int kidx, input int gap);
    logic [11:0] v;
    v = 12'h001 << kidx;
    press(v, gap);
  endtask

  task automatic keys(input int ks[$], input int last_gap);
    foreach (ks[i]) key(ks[i], (i == ks.size() - 1) ? last_gap : 10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_open", int'(open), 0);
    check("rst_prog", int'(prog_mode), 0);
    check("rst_lock", int'(locked_out), 0);
    check("rst_fail_cnt", int'(fail_cnt), 0);
    m_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic obs(input kind_e k);
    exp_t x;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_%s: got event want none (cyc %0d)",
               k.name(), cyc);
    end else begin
      x = expq.pop_front();
      check({k.name(), "_kind"}, int'(k), int'(x.kind));
      check({k.name(), "_cycle"}, cyc, x.at);
      if (k == K_ERR) check("err_fail_cnt", int'(fail_cnt), x.fails);
    end
  endtask

  initial begin
    logic p_open, p_lock, p_prog;
    int   olen, llen;
    p_open = 0; p_lock = 0; p_prog = 0; olen = 0; llen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        p_open = 0; p_lock = 0; p_prog = 0; olen = 0; llen = 0;
      end else begin
        if (err) obs(K_ERR);
        if (open && !p_open) obs(K_OPEN);
        if (locked_out && !p_lock) obs(K_LOCK);
        if (prog_mode && !p_prog) obs(K_PROG);
        if (open) olen++;
        else if (p_open) begin
          if (!prog_mode) check("open_len", olen, OC);
          olen = 0;
        end
        if (locked_out) llen++;
        else if (p_lock) begin
          check("lock_len", llen, LC);
          check("lock_exit_fail_cnt", int'(fail_cnt), 0);
          llen = 0;
        end
        p_open = open;
        p_lock = locked_out;
        p_prog = prog_mode;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int ks[$];
    int r, n;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_open", int'(open), 0);
    check("init_lock", int'(locked_out), 0);
    check("init_prog", int'(prog_mode), 0);
    check("init_err", int'(err), 0);
    check("init_fail_cnt", int'(fail_cnt), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    keys('{1, 2, 3, 4, 5, 6}, 10);
    keys('{1, 2, 11, 1, 2, 3, 4, 5, 6}, 10);
    // '*' lands on the expiry edge and must be dropped.
    keys('{1, 2, 3, 4, 5, 6}, 11);
    key(10, 10);
    repeat (3) keys('{2, 6, 1, 4, 3, 5}, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);
    key(11, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);
    keys('{10, 9, 8, 7, 6, 5, 4, 11}, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);
    keys('{9, 8, 7, 6, 5, 4}, 10);
    keys('{1, 2, 3}, 10);
    do_reset();
    keys('{4, 5, 6, 11}, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);
    check("open_before_rst", int'(open), 1);
    do_reset();
    keys('{1, 2, 3, 4, 5, 6}, 10);
    keys('{10, 1, 2, 3, 11}, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);
    press(12'h006, 10);
    keys('{1, 2, 3, 4, 5, 6}, 10);

    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 19);
      ks.delete();
      if (r < 6) begin
        for (int i = 0; i < CL; i++) ks.push_back(code[i]);
        keys(ks, $urandom_range(3, 14));
        if (r < 3) begin
          ks.delete();
          ks.push_back(10);
          n = $urandom_range(CL - 1, CL + 1);
          for (int i = 0; i < n; i++) ks.push_back($urandom_range(0, 9));
          ks.push_back(($urandom_range(0, 3) == 0) ? 10 : 11);
          keys(ks, 10);
        end
      end else if (r < 10) begin
        for (int i = 0; i < CL; i++) ks.push_back($urandom_range(0, 9));
        keys(ks, $urandom_range(3, 14));
      end else if (r < 14) begin
        key($urandom_range(0, 11), $urandom_range(3, 14));
      end else if (r < 16) begin
        int a, b;
        logic [11:0] v;
        a = $urandom_range(0, 11);
        b = (a + $urandom_range(1, 11)) % 12;
        v = (12'h001 << a) | (12'h001 << b);
        press(v, 10);
      end else if (r < 19) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) ks.push_back($urandom_range(0, 9));
        ks.push_back(11);
        keys(ks, 10);
      end else begin
        do_reset();
      end
    end

    repeat (120) @(posedge clk);
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
